// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the shift-and-add multiply sequencer: FSM states,
// ALU operation codes {c12,c13} and operand/counter widths.
package alu_ctrl_pkg;

  localparam int unsigned N_BITS = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // ALU control word {c12, c13}
  localparam logic [1:0] ALU_OP_SHL = 2'b00;
  localparam logic [1:0] ALU_OP_SHR = 2'b01;
  localparam logic [1:0] ALU_OP_ADD = 2'b10;
  localparam logic [1:0] ALU_OP_SUB = 2'b11;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Unsigned 8x8->16 shift-and-add multiplier that borrows the shared ALU.
// Optional feature macro: ALU_SKIP_ZERO_EN (skip ADD when the multiplier LSB is 0).
module alu_mul_sequencer
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] op_a,
  input  logic [N_BITS-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N_BITS-1:0] product,
  output logic              product_zero,
  output logic              alu_c12,
  output logic              alu_c13,
  output logic [N_BITS-1:0] alu_a,
  output logic [N_BITS-1:0] alu_b,
  input  logic [N_BITS-1:0] alu_result,
  input  logic              alu_carry
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N_BITS-1:0] r_p;
  logic [N_BITS-1:0] r_q;
  logic [N_BITS-1:0] r_m;
  logic              r_c;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        w_alu_op;
  logic [N_BITS-1:0] w_q_shift;
  logic              w_last;

  // Multiplier after the right shift; its LSB decides the next slot when skipping
  assign w_q_shift = {alu_carry, r_q[N_BITS-1:1]};
  assign w_last    = (r_cnt == CNT_W'(N_BITS - 1));

  // State and datapath storage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_p     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_m   <= op_a;
            r_q   <= op_b;
            r_p   <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
          end
        end
        ST_ADD: begin
          r_p <= alu_result;
          r_c <= alu_carry;
        end
        ST_SHIFT: begin
          // Adder carry is the 9th product bit; it re-enters at P[7]
          r_p   <= {r_c, alu_result[N_BITS-2:0]};
          r_q   <= w_q_shift;
          r_c   <= 1'b0;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_SKIP_ZERO_EN
          w_state_nxt = op_b[0] ? ST_ADD : ST_SHIFT;
`else
          w_state_nxt = ST_ADD;
`endif
        end
      end
      ST_ADD:   w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
`ifdef ALU_SKIP_ZERO_EN
          w_state_nxt = w_q_shift[0] ? ST_ADD : ST_SHIFT;
`else
          w_state_nxt = ST_ADD;
`endif
        end
      end
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and ALU drive decode; ALU is idle (all zero) outside ADD/SHIFT
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_alu_op  = ALU_OP_SHL;
    alu_a     = '0;
    alu_b     = '0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_ADD: begin
        w_alu_op = ALU_OP_ADD;
        alu_a    = r_p;
        alu_b    = r_q[0] ? r_m : '0;
      end
      ST_SHIFT: begin
        w_alu_op = ALU_OP_SHR;
        alu_a    = r_p;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign {alu_c12, alu_c13} = w_alu_op;
  assign product            = {r_p, r_q};
  assign product_zero       = out_valid && (product == '0);

endmodule
